// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: FSM state encoding, address-field
// layout of the matrix port and the address builder used by the top level.
//
// Address layout of wr_addr / rd_addr:
//   [31:24] ADDR_MASK, [23:13] destination index d, [12:2] source index s, [1:0] 0

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'hC0
`endif

package weight_loader_pkg;

  localparam int IDX_W    = 11;
  localparam int S_LSB    = 2;
  localparam int D_LSB    = 13;
  localparam int MASK_LSB = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [31:0] pair_addr(input logic [7:0]       mask,
                                            input logic [IDX_W-1:0] s,
                                            input logic [IDX_W-1:0] d);
    logic [31:0] a;
    a                  = '0;
    a[MASK_LSB +: 8]   = mask;
    a[D_LSB +: IDX_W]  = d;
    a[S_LSB +: IDX_W]  = s;
    return a;
  endfunction

endpackage

// File: rtl/weight_loader_pair_counter.sv
// pair_counter: (s, d) index walker for the weight loader. s is the inner
// index, d the outer one; both run 0..N-1.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return both indices to 0
//   adv        : step to the next (s, d) pair (s first, wrapping into d)
//   s, d       : current indices
//   last       : current pair is (N-1, N-1)

module pair_counter
  import weight_loader_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] s,
  output logic [IDX_W-1:0] d,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

  assign last = (s == IDX_MAX) && (d == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      d <= '0;
    end else if (clr) begin
      s <= '0;
      d <= '0;
    end else if (adv) begin
      if (s == IDX_MAX) begin
        s <= '0;
        // Wrapping out of the final pair lands on (0,0) for the next run.
        d <= last ? '0 : d + 1'b1;
      end else begin
        s <= s + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams an N x N weight matrix into a matrix memory
// (mode 0) or reads all N*N weights back out as a stream (mode 1).
// Word order is d outer, s inner.
//
// Ports:
//   clk, axi_rstn            : clock, asynchronous active-low reset
//   start, mode              : operation request (mode sampled with start)
//   busy, done               : operation in progress / one-cycle completion pulse
//   s_valid, s_ready, s_data : weight input stream (write mode)
//   m_valid, m_ready, m_data : readback stream (read mode)
//   wready, wr_addr, wdata   : matrix write strobe, address and data
//   rd_addr, rdata           : matrix read address and combinational read data

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'hC0
`endif

module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int         N         = 8,
  parameter logic [7:0] ADDR_MASK = `WEIGHT_ADDR_MASK
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        start,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        wready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rdata
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_s, idx_d;
  logic             idx_last;
  logic             cnt_clr, cnt_adv;
  logic             wr_fire, rd_take;
  logic             vld_p1;
  logic             m_vld_p1;

  pair_counter #(.N(N)) u_pair_counter (
    .clk   (clk),
    .rst_n (axi_rstn),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .s     (idx_s),
    .d     (idx_d),
    .last  (idx_last)
  );

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    wr_fire = 1'b0;
    rd_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = mode ? RD_ADDR : WRITE;
        end
      end
      WRITE: begin
        if (s_valid) begin
          wr_fire = 1'b1;
          cnt_adv = 1'b1;
          if (idx_last) state_d = DONE;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (m_vld_p1 && m_ready) begin
          rd_take = 1'b1;
          cnt_adv = 1'b1;
          state_d = idx_last ? DONE : RD_ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign s_ready = (state_q == WRITE);

  // Stage p1: matrix write, one cycle after the stream handshake.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      vld_p1  <= 1'b0;
      wr_addr <= '0;
      wdata   <= '0;
    end else begin
      vld_p1 <= wr_fire;
      if (wr_fire) begin
        wr_addr <= pair_addr(ADDR_MASK, idx_s, idx_d);
        wdata   <= s_data;
      end
    end
  end

  assign wready = vld_p1;

  // Readback: rd_addr is registered in RD_ADDR; rdata settles from it, and the
  // first RD_DATA cycle captures it into m_data. m_data then holds until the
  // handshake.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_addr  <= '0;
      m_data   <= '0;
      m_vld_p1 <= 1'b0;
    end else begin
      if (state_q == RD_ADDR) rd_addr <= pair_addr(ADDR_MASK, idx_s, idx_d);
      if ((state_q == RD_DATA) && !m_vld_p1) begin
        m_data   <= rdata;
        m_vld_p1 <= 1'b1;
      end else if (rd_take) begin
        m_vld_p1 <= 1'b0;
      end
    end
  end

  assign m_valid = m_vld_p1;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader with N=4 and an explicit address mask.
module tb_weight_loader;

  localparam int         N    = 4;
  localparam int         NW   = N * N;
  localparam logic [7:0] MASK = 8'hA3;

  logic        clk, axi_rstn, start, mode;
  logic        busy, done;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        wready;
  logic [31:0] wr_addr, wdata, rd_addr, rdata;

  weight_loader #(.N(N), .ADDR_MASK(MASK)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
    .rd_addr(rd_addr), .rdata(rdata)
  );

  // Matrix memory model for readback.
  assign rdata = rd_addr ^ 32'h0000_00A5;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wdata_log[$];
  int          wr_cyc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_pulses = 0;
  int rd_cnt    = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int start_cyc = 0;
  bit in_read   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    logic [10:0] s, d;
    s = 11'(k % N);
    d = 11'(k / N);
    return {MASK, d, s, 2'b00};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial forever begin
    wr_t e;
    logic [31:0] er;
    @(negedge clk);
    if (!axi_rstn) begin
      exp_wr.delete();
    end else begin
      if (in_read) chk("wready_in_read", {31'd0, wready}, 32'd0);
      if (wready) begin
        wr_pulses++;
        wr_addr_log.push_back(wr_addr);
        wdata_log.push_back(wdata);
        wr_cyc_log.push_back(cyc);
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wdata", wdata, e.data);
        end
      end
      if (m_valid && m_ready) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          chk("rd_unexpected_word", 32'd1, 32'd0);
        end else begin
          er = exp_rd.pop_front();
          chk("m_data", m_data, er);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_done"},    {31'd0, done},    32'd0);
    chk({tag, "_wready"},  {31'd0, wready},  32'd0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wdata"},   wdata,   32'd0);
    chk({tag, "_rd_addr"}, rd_addr, 32'd0);
    chk({tag, "_m_data"},  m_data,  32'd0);
  endtask

  task automatic pulse_start(input logic md);
    @(posedge clk); #1;
    start = 1; mode = md; start_cyc = cyc;
    @(posedge clk); #1;
    start = 0; mode = 0;
  endtask

  task automatic wait_done(input int dbase, input string nm);
    int w;
    w = 0;
    while (done_cnt == dbase && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (done_cnt == dbase) chk({nm, "_done_timeout"}, 32'd1, 32'd0);
  endtask

  // Write run: data = dbase_val + k. start_at re-asserts start (with mode=1)
  // at that word; rst_at pulses reset at that word and abandons the run.
  task automatic do_write(input logic [31:0] dbase_val, input bit toggle,
                          input int start_at, input int rst_at, input int dbase);
    int k, n;
    bit hs, started;
    k = 0; n = 0; started = 0;
    pulse_start(1'b0);
    while (k < NW && n < 200) begin
      s_valid = toggle ? ((n % 2) == 0) : 1'b1;
      s_data  = dbase_val + 32'(k);
      if (k == start_at && !started) begin
        start = 1; mode = 1; started = 1;
      end else begin
        start = 0; mode = 0;
      end
      if (k == rst_at) begin
        axi_rstn = 0; start = 0; s_valid = 0;
        #1;
        chk_all_zero("in_reset");
        @(posedge clk); #1;
        chk_all_zero("in_reset_hold");
        @(posedge clk); #1;
        axi_rstn = 1;
        return;
      end
      hs = s_valid && s_ready;
      if (hs) exp_wr.push_back('{exp_addr(k), dbase_val + 32'(k)});
      @(posedge clk); #1;
      if (hs) k++;
      n++;
    end
    s_valid = 0; start = 0; mode = 0;
    if (k != NW) chk("write_timeout", 32'(k), 32'(NW));
    wait_done(dbase, "write");
  endtask

  task automatic do_read(input int hold);
    int n, w, rbase, dbase;
    bit held;
    in_read = 1;
    for (int k = 0; k < NW; k++) exp_rd.push_back(exp_addr(k) ^ 32'h0000_00A5);
    rbase = rd_cnt; dbase = done_cnt;
    m_ready = 1; held = 0; n = 0;
    pulse_start(1'b1);
    while (done_cnt == dbase && n < 300) begin
      if (hold >= 0 && !held && (rd_cnt - rbase) == hold) begin
        m_ready = 0;
        w = 0;
        while (!m_valid && w < 20) begin
          @(posedge clk); #1;
          w++;
        end
        for (int c = 0; c < 5; c++) begin
          chk("hold_m_valid", {31'd0, m_valid}, 32'd1);
          chk("hold_m_data",  m_data,  exp_addr(hold) ^ 32'h0000_00A5);
          chk("hold_rd_addr", rd_addr, exp_addr(hold));
          @(posedge clk); #1;
        end
        m_ready = 1;
        held = 1;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (done_cnt == dbase) chk("read_done_timeout", 32'd1, 32'd0);
    chk("read_word_count", 32'(rd_cnt - rbase), 32'(NW));
    chk("read_done_count", 32'(done_cnt - dbase), 32'd1);
    @(negedge clk);
    in_read = 0;
  endtask

  initial begin
    int base, dbase;
    axi_rstn = 0; start = 0; mode = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    axi_rstn = 1;

    // Continuous write.
    base = wr_pulses; dbase = done_cnt;
    do_write(32'h100, 1'b0, -1, -1, dbase);
    chk("w1_pulses", 32'(wr_pulses - base), 32'(NW));
    chk("w1_word5_addr", wr_addr_log[base + 5], {MASK, 24'h002004});
    chk("w1_word5_data", wdata_log[base + 5], 32'h105);
    chk("w1_back_to_back", 32'(wr_cyc_log[base + NW - 1] - wr_cyc_log[base]), 32'(NW - 1));
    chk("w1_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("w1_done_latency", 32'(done_cyc - start_cyc), 32'd17);
    chk("w1_done_with_last", 32'(done_cyc), 32'(wr_cyc_log[base + NW - 1]));
    @(negedge clk);
    chk("w1_idle_busy", {31'd0, busy}, 32'd0);

    // Throttled write.
    base = wr_pulses; dbase = done_cnt;
    do_write(32'h300, 1'b1, -1, -1, dbase);
    chk("w2_pulses", 32'(wr_pulses - base), 32'(NW));
    chk("w2_done_count", 32'(done_cnt - dbase), 32'd1);

    // start (mode=1) during WRITE at word 7 is ignored.
    base = wr_pulses; dbase = done_cnt;
    do_write(32'h500, 1'b0, 7, -1, dbase);
    chk("w3_pulses", 32'(wr_pulses - base), 32'(NW));
    chk("w3_done_count", 32'(done_cnt - dbase), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("w3_idle_after", {31'd0, busy}, 32'd0);

    // Readback, free-flowing and with a 5-cycle stall on word 3.
    do_read(-1);
    do_read(3);

    // Reset mid-write at word 9, then a fresh write.
    dbase = done_cnt;
    do_write(32'h700, 1'b0, -1, 9, dbase);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(done_cnt - dbase), 32'd0);
    base = wr_pulses; dbase = done_cnt;
    do_write(32'h900, 1'b0, -1, -1, dbase);
    chk("rst_restart_pulses", 32'(wr_pulses - base), 32'(NW));
    chk("rst_restart_addr0", wr_addr_log[base], {MASK, 24'h000000});
    chk("rst_restart_data0", wdata_log[base], 32'h900);
    chk("rst_restart_done", 32'(done_cnt - dbase), 32'd1);

    repeat (3) @(posedge clk);
    chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
